local_hist_predictor: RTL
=========================

LOCAL_HIST_PREDICTOR -- requirements
Module: local_hist_predictor

Interface
REQ-001 The block SHALL have parameter LHT_ENTRIES, default 16, meaning local-history-table entries (power of 2, >=2).
REQ-002 The block SHALL have parameter HIST_BITS, default 4, meaning history length; the pattern table has 2^HIST_BITS entries.
REQ-003 The block SHALL have parameter N_FETCH, default 2, meaning number of prediction (lookup) ports.
REQ-004 The block SHALL have parameter N_RESOLVE, default 2, meaning number of branch-resolve (update) ports.
REQ-005 The block SHALL have parameter CTR_INIT, default 2'b01, meaning the pattern counter reset value (weakly not-taken).
REQ-006 The block SHALL have parameter CNT_BITS, default 16, meaning mispredict statistics counter width.
REQ-007 The block SHALL have port clock, input, 1, the single clock.
REQ-008 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 The block SHALL have port enable, input, 1, which gates predictions and updates.
REQ-010 The block SHALL have port fetch_pc, input, N_FETCH x 64, lookup PCs.
REQ-011 The block SHALL have port fetch_valid, input, N_FETCH, per-port lookup valid.
REQ-012 The block SHALL have port predict_taken, output, N_FETCH, predicted direction.
REQ-013 The block SHALL have port predict_valid, output, N_FETCH, prediction valid.
REQ-014 The block SHALL have port resolve_pc, input, N_RESOLVE x 64, resolved branch PCs.
REQ-015 The block SHALL have port resolve_taken, input, N_RESOLVE, actual direction.
REQ-016 The block SHALL have port resolve_valid, input, N_RESOLVE, per-port resolve valid.
REQ-017 The block SHALL have port mispredict, output, N_RESOLVE, registered mispredict flag.
REQ-018 The block SHALL have port mispredict_valid, output, N_RESOLVE, registered flag valid.
REQ-019 The block SHALL have port mispredict_count, output, CNT_BITS, saturating total mispredicts.

Function
REQ-020 LHT index SHALL be pc[$clog2(LHT_ENTRIES)+1:2]; PC bits [1:0] and upper bits SHALL be ignored.
REQ-021 Lookup SHALL be combinational from registered state: predict_taken[k] = MSB of PHT[LHT[idx(fetch_pc[k])]]; predict_valid[k] = fetch_valid[k] & enable; predict_taken[k] = 0 when not valid.
REQ-022 Lookups SHALL NOT see same-cycle resolve updates (no bypass).
REQ-023 Updates SHALL occur only when resolve_valid[k] & enable; otherwise that port has no effect and mispredict_valid[k] = 0 next cycle.
REQ-024 Per valid resolve: with h = current LHT[idx], the 2-bit counter PHT[h] SHALL be incremented if taken and not 2'b11, decremented if not-taken and not 2'b00, otherwise held; LHT[idx] SHALL become {h[HIST_BITS-2:0], taken}.
REQ-025 Resolve ports SHALL be applied sequentially in port order 0..N_RESOLVE-1 within one cycle; port k SHALL observe LHT/PHT state including effects of ports <k (same-entry collisions accumulate, never drop).
REQ-026 mispredict[k] SHALL equal (MSB of PHT[h] as observed by port k before its own update) XOR resolve_taken[k], registered, and appear with mispredict_valid[k]=1 exactly one cycle after the resolve.
REQ-027 mispredict_count SHALL add the number of set mispredict flags of the cycle (0..N_RESOLVE) on the same edge those flags are registered, saturating at all-ones, never wrapping.

Reset
REQ-028 Asserting reset SHALL immediately (without clock) set all LHT entries to 0, all PHT counters to CTR_INIT, mispredict, mispredict_valid and mispredict_count to 0.
REQ-029 Reset asserted mid-operation SHALL discard any update of that cycle; predict outputs SHALL reflect reset state combinationally.
REQ-030 The first update SHALL take effect at the first rising clock edge with reset deasserted.

Verification
REQ-031 After reset, enable=1, fetch_pc[0]=0x10 valid -> predict_valid[0]=1, predict_taken[0]=0.
REQ-032 Resolve pc 0x10 taken on port 0 five cycles -> PHT[0],[1],[3],[7],[15]=2'b10, LHT[4]=4'b1111, five mispredict=1, count=5; sixth taken -> PHT[15]=2'b11, mispredict=0, then fetch 0x10 predicts 1.
REQ-033 From reset, both ports resolve pc 0x10 taken same cycle -> PHT[0]=PHT[1]=2'b10, LHT[4]=4'b0011, both mispredict=1, count=2 next cycle.
REQ-034 enable=0 with valid fetch/resolve -> predict_valid=0, no state change, mispredict_valid=0.
REQ-035 CNT_BITS=2, four mispredicting resolves -> mispredict_count sticks at 2'b11.
REQ-036 Reset pulsed between clock edges after training -> outputs and counter 0 immediately, fetch 0x10 predicts 0.

Source files
------------

// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor: a per-PC history table selects a
// 2-bit counter in a shared pattern table; resolves update both in port order.
module local_hist_predictor #(
  parameter int         LHT_ENTRIES = 16,
  parameter int         HIST_BITS   = 4,
  parameter int         N_FETCH     = 2,
  parameter int         N_RESOLVE   = 2,
  parameter logic [1:0] CTR_INIT    = 2'b01,
  parameter int         CNT_BITS    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_FETCH*64-1:0]     fetch_pc,
  input  logic [N_FETCH-1:0]        fetch_valid,
  output logic [N_FETCH-1:0]        predict_taken,
  output logic [N_FETCH-1:0]        predict_valid,
  input  logic [N_RESOLVE*64-1:0]   resolve_pc,
  input  logic [N_RESOLVE-1:0]      resolve_taken,
  input  logic [N_RESOLVE-1:0]      resolve_valid,
  output logic [N_RESOLVE-1:0]      mispredict,
  output logic [N_RESOLVE-1:0]      mispredict_valid,
  output logic [CNT_BITS-1:0]       mispredict_count
);

  localparam int IDX_W       = $clog2(LHT_ENTRIES);
  localparam int PHT_ENTRIES = 1 << HIST_BITS;
  localparam int POP_W       = $clog2(N_RESOLVE + 1);
  localparam int SUM_W       = CNT_BITS + POP_W;

  logic [HIST_BITS-1:0] lht     [LHT_ENTRIES];
  logic [1:0]           pht     [PHT_ENTRIES];
  logic [HIST_BITS-1:0] lht_nxt [LHT_ENTRIES];
  logic [1:0]           pht_nxt [PHT_ENTRIES];
  logic [N_RESOLVE-1:0] mp_nxt;
  logic [N_RESOLVE-1:0] mv_nxt;
  logic [CNT_BITS-1:0]  count_nxt;

  function automatic logic [IDX_W-1:0] lht_idx(input logic [63:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_BITS{1'b1}})) return '1;
    return s[CNT_BITS-1:0];
  endfunction

  // Lookup: purely from registered state, so same-cycle resolves are invisible
  always_comb begin
    predict_valid = '0;
    predict_taken = '0;
    for (int k = 0; k < N_FETCH; k++) begin
      predict_valid[k] = fetch_valid[k] & enable;
      predict_taken[k] = fetch_valid[k] & enable &
                         pht[lht[lht_idx(fetch_pc[k*64 +: 64])]][1];
    end
  end

  // Update: ports chained in order so colliding resolves see earlier effects
  always_comb begin
    logic [IDX_W-1:0]     idx;
    logic [HIST_BITS-1:0] h;
    logic [POP_W-1:0]     pop;
    lht_nxt = lht;
    pht_nxt = pht;
    mp_nxt  = '0;
    mv_nxt  = '0;
    idx     = '0;
    h       = '0;
    pop     = '0;
    for (int k = 0; k < N_RESOLVE; k++) begin
      if (resolve_valid[k] && enable) begin
        idx          = lht_idx(resolve_pc[k*64 +: 64]);
        h            = lht_nxt[idx];
        mv_nxt[k]    = 1'b1;
        mp_nxt[k]    = pht_nxt[h][1] ^ resolve_taken[k];
        pht_nxt[h]   = ctr_step(pht_nxt[h], resolve_taken[k]);
        lht_nxt[idx] = HIST_BITS'({h, resolve_taken[k]});
        pop          = pop + POP_W'(mp_nxt[k]);
      end
    end
    count_nxt = sat_add(mispredict_count, pop);
  end

  // State and registered mispredict outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LHT_ENTRIES; i++) lht[i] <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CTR_INIT;
      mispredict       <= '0;
      mispredict_valid <= '0;
      mispredict_count <= '0;
    end else begin
      for (int i = 0; i < LHT_ENTRIES; i++) lht[i] <= lht_nxt[i];
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= pht_nxt[i];
      mispredict       <= mp_nxt;
      mispredict_valid <= mv_nxt;
      mispredict_count <= count_nxt;
    end
  end

endmodule
